register_file_2r1w: RTL and testbench

//  Responder side of the operand-fetch register interface: 2 read ports, 1 write port, DATA_W-bit general register file.

---
 rtl/register_file_2r1w.sv | 187 ++++++++++++++++++
 tb/tb_register_file_2r1w.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// ============================================================================
// Module      : register_file_2r1w
// Description : 2-read / 1-write general register file with registered read
//               data and a sequential clear sweep after reset or on clr_req.
//               Optional write-to-read bypass: define REGFILE_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_2r1w #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int R0_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr_req,
    output logic              ready,
    input  logic              reg_r_en_a,
    input  logic [ADDR_W-1:0] reg_r_idx_a,
    output logic [DATA_W-1:0] reg_r_data_a,
    output logic              reg_r_valid_a,
    input  logic              reg_r_en_b,
    input  logic [ADDR_W-1:0] reg_r_idx_b,
    output logic [DATA_W-1:0] reg_r_data_b,
    output logic              reg_r_valid_b,
    input  logic              reg_w_en,
    input  logic [ADDR_W-1:0] reg_w_idx,
    input  logic [DATA_W-1:0] reg_w_data
);

    localparam int                c_DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(c_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);
    localparam logic              c_R0_ZERO = (R0_ZERO != 0);

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                r_ready;

    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    logic                w_w_r0;
    logic                w_wr_accept;
    logic [DATA_W-1:0]   w_rd_a;
    logic [DATA_W-1:0]   w_rd_b;
    logic [DATA_W-1:0]   r_data_a;
    logic [DATA_W-1:0]   r_data_b;
    logic                r_valid_a;
    logic                r_valid_b;

    // A write is dropped outside READY, when it targets a hardwired r0, or
    // when it coincides with a clear request.
    assign w_w_r0      = c_R0_ZERO && (reg_w_idx == '0);
    assign w_wr_accept = (r_state == S_READY) && reg_w_en && !clr_req && !w_w_r0;

    // ------------------------------------------------------------------
    // Control FSM: state, sweep counter and the registered ready flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_INIT;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == S_READY);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mem_we    = 1'b0;
        w_mem_addr  = reg_w_idx;
        w_mem_wdata = reg_w_data;
        case (r_state)
            S_INIT: begin
                w_mem_we    = 1'b1;
                w_mem_addr  = r_cnt;
                w_mem_wdata = '0;
                if (clr_req) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = S_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end
            end
            S_READY: begin
                if (clr_req) begin
                    w_state_nxt = S_INIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_mem_we = w_wr_accept;
                end
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage carries no reset; the INIT sweep zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read-data selection (bypass, then the r0 override on top)
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_a = r_mem[reg_r_idx_a];
        w_rd_b = r_mem[reg_r_idx_b];
`ifdef REGFILE_BYPASS_EN
        if (w_wr_accept && (reg_w_idx == reg_r_idx_a)) begin
            w_rd_a = reg_w_data;
        end
        if (w_wr_accept && (reg_w_idx == reg_r_idx_b)) begin
            w_rd_b = reg_w_data;
        end
`else
        if (w_wr_accept && (reg_w_idx == reg_r_idx_a)) begin
            w_rd_a = r_mem[reg_r_idx_a];
        end
        if (w_wr_accept && (reg_w_idx == reg_r_idx_b)) begin
            w_rd_b = r_mem[reg_r_idx_b];
        end
`endif
        if (c_R0_ZERO && (reg_r_idx_a == '0)) begin
            w_rd_a = '0;
        end
        if (c_R0_ZERO && (reg_r_idx_b == '0)) begin
            w_rd_b = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registered read ports
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_a  <= '0;
            r_valid_a <= 1'b0;
            r_data_b  <= '0;
            r_valid_b <= 1'b0;
        end else if (r_state != S_READY) begin
            r_data_a  <= '0;
            r_valid_a <= 1'b0;
            r_data_b  <= '0;
            r_valid_b <= 1'b0;
        end else begin
            r_valid_a <= reg_r_en_a;
            r_valid_b <= reg_r_en_b;
            if (reg_r_en_a) begin
                r_data_a <= w_rd_a;
            end
            if (reg_r_en_b) begin
                r_data_b <= w_rd_b;
            end
        end
    end

    assign ready         = r_ready;
    assign reg_r_data_a  = r_data_a;
    assign reg_r_valid_a = r_valid_a;
    assign reg_r_data_b  = r_data_b;
    assign reg_r_valid_b = r_valid_b;

endmodule

`default_nettype wire

// File: tb/tb_register_file_2r1w.sv
// ============================================================================
// Module      : tb_register_file_2r1w
// Description : Self-checking bench for register_file_2r1w against an
//               array-based reference model of the register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_2r1w;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 5;
    localparam int R0_ZERO = 1;
    localparam int DEPTH   = 2 ** ADDR_W;

    logic              clk;
    logic              reset;
    logic              clr_req;
    logic              ready;
    logic              reg_r_en_a;
    logic [ADDR_W-1:0] reg_r_idx_a;
    logic [DATA_W-1:0] reg_r_data_a;
    logic              reg_r_valid_a;
    logic              reg_r_en_b;
    logic [ADDR_W-1:0] reg_r_idx_b;
    logic [DATA_W-1:0] reg_r_data_b;
    logic              reg_r_valid_b;
    logic              reg_w_en;
    logic [ADDR_W-1:0] reg_w_idx;
    logic [DATA_W-1:0] reg_w_data;

    int n_cmp;
    int n_err;

    // Reference model state
    logic [DATA_W-1:0] mdl_mem [DEPTH];
    int                mdl_init_left;
    logic [DATA_W-1:0] mdl_data_a;
    logic [DATA_W-1:0] mdl_data_b;
    logic              mdl_valid_a;
    logic              mdl_valid_b;

    register_file_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .R0_ZERO(R0_ZERO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .clr_req      (clr_req),
        .ready        (ready),
        .reg_r_en_a   (reg_r_en_a),
        .reg_r_idx_a  (reg_r_idx_a),
        .reg_r_data_a (reg_r_data_a),
        .reg_r_valid_a(reg_r_valid_a),
        .reg_r_en_b   (reg_r_en_b),
        .reg_r_idx_b  (reg_r_idx_b),
        .reg_r_data_b (reg_r_data_b),
        .reg_r_valid_b(reg_r_valid_b),
        .reg_w_en     (reg_w_en),
        .reg_w_idx    (reg_w_idx),
        .reg_w_data   (reg_w_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] mdl_read(input logic [ADDR_W-1:0] idx, input logic wr_ok);
        if (R0_ZERO != 0 && idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && idx == reg_w_idx) return reg_w_data;
`endif
        return mdl_mem[idx];
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
        mdl_init_left = DEPTH;
        mdl_data_a    = '0;
        mdl_data_b    = '0;
        mdl_valid_a   = 1'b0;
        mdl_valid_b   = 1'b0;
    endtask

    task automatic idle();
        clr_req    = 1'b0;
        reg_r_en_a = 1'b0;
        reg_r_en_b = 1'b0;
        reg_w_en   = 1'b0;
    endtask

    // One clock edge: advance the model with the inputs applied, then settle.
    task automatic cycle();
        logic was_ready;
        logic wr_ok;
        @(posedge clk);
        was_ready = (mdl_init_left == 0);
        wr_ok = was_ready && reg_w_en && !clr_req && !(R0_ZERO != 0 && reg_w_idx == 0);
        if (was_ready) begin
            mdl_valid_a = reg_r_en_a;
            mdl_valid_b = reg_r_en_b;
            if (reg_r_en_a) mdl_data_a = mdl_read(reg_r_idx_a, wr_ok);
            if (reg_r_en_b) mdl_data_b = mdl_read(reg_r_idx_b, wr_ok);
        end else begin
            mdl_valid_a = 1'b0;
            mdl_valid_b = 1'b0;
            mdl_data_a  = '0;
            mdl_data_b  = '0;
        end
        if (clr_req) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
            mdl_init_left = DEPTH;
        end else if (was_ready) begin
            if (wr_ok) mdl_mem[reg_w_idx] = reg_w_data;
        end else begin
            mdl_init_left--;
        end
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] data);
        idle();
        reg_w_en   = 1'b1;
        reg_w_idx  = idx;
        reg_w_data = data;
        cycle();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reg_r_idx_a = '0;
        reg_r_idx_b = '0;
        reg_w_idx   = '0;
        reg_w_data  = '0;
        reset = 1'b0;
        mdl_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b0 || reg_r_valid_a !== 1'b0 || reg_r_valid_b !== 1'b0 ||
            reg_r_data_a !== '0 || reg_r_data_b !== '0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b va=%b vb=%b da=%h db=%h expected all 0",
                     ready, reg_r_valid_a, reg_r_valid_b, reg_r_data_a, reg_r_data_b);
        end
        reset = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            n_cmp++;
            if (ready !== (i >= DEPTH)) begin
                n_err++;
                $display("FAIL init_ready cyc%0d: got %b expected %b", i, ready, (i >= DEPTH));
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            reg_r_en_a  = 1'b1;
            reg_r_idx_a = ADDR_W'(i);
            reg_r_en_b  = 1'b1;
            reg_r_idx_b = ADDR_W'(DEPTH - 1 - i);
            cycle();
            n_cmp++;
            if (reg_r_valid_a !== 1'b1 || reg_r_valid_b !== 1'b1 ||
                reg_r_data_a !== 16'h0000 || reg_r_data_b !== 16'h0000) begin
                n_err++;
                $display("FAIL cleared_read idx%0d: va=%b vb=%b da=%h db=%h expected 1 1 0000 0000",
                         i, reg_r_valid_a, reg_r_valid_b, reg_r_data_a, reg_r_data_b);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_write_read();
        do_write(5'd5, 16'hBEEF);
        reg_r_en_a  = 1'b1;
        reg_r_idx_a = 5'd5;
        reg_r_en_b  = 1'b1;
        reg_r_idx_b = 5'd5;
        cycle();
        idle();
        n_cmp++;
        if (reg_r_data_a !== 16'hBEEF || reg_r_data_b !== 16'hBEEF ||
            reg_r_valid_a !== 1'b1 || reg_r_valid_b !== 1'b1) begin
            n_err++;
            $display("FAIL rd_r5: da=%h db=%h va=%b vb=%b expected BEEF BEEF 1 1",
                     reg_r_data_a, reg_r_data_b, reg_r_valid_a, reg_r_valid_b);
        end
        cycle();
        n_cmp++;
        if (reg_r_valid_a !== 1'b0 || reg_r_valid_b !== 1'b0 ||
            reg_r_data_a !== 16'hBEEF || reg_r_data_b !== 16'hBEEF) begin
            n_err++;
            $display("FAIL rd_hold: va=%b vb=%b da=%h db=%h expected 0 0 BEEF BEEF",
                     reg_r_valid_a, reg_r_valid_b, reg_r_data_a, reg_r_data_b);
        end
    endtask

    task automatic test_r0();
        logic [DATA_W-1:0] exp;
        exp = (R0_ZERO != 0) ? 16'h0000 : 16'h1234;
        do_write(5'd0, 16'h1234);
        reg_r_en_a  = 1'b1;
        reg_r_idx_a = 5'd0;
        cycle();
        idle();
        n_cmp++;
        if (reg_r_data_a !== exp || reg_r_valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL r0_read: got %h/%b expected %h/1", reg_r_data_a, reg_r_valid_a, exp);
        end
    endtask

    task automatic test_collision();
        logic [DATA_W-1:0] exp;
`ifdef REGFILE_BYPASS_EN
        exp = 16'h00A5;
`else
        exp = 16'h0011;
`endif
        do_write(5'd7, 16'h0011);
        reg_w_en    = 1'b1;
        reg_w_idx   = 5'd7;
        reg_w_data  = 16'h00A5;
        reg_r_en_b  = 1'b1;
        reg_r_idx_b = 5'd7;
        cycle();
        reg_w_en = 1'b0;
        n_cmp++;
        if (reg_r_data_b !== exp) begin
            n_err++;
            $display("FAIL collide_rd: got %h expected %h", reg_r_data_b, exp);
        end
        cycle();
        idle();
        n_cmp++;
        if (reg_r_data_b !== 16'h00A5 || reg_r_valid_b !== 1'b1) begin
            n_err++;
            $display("FAIL after_collide: got %h/%b expected 00a5/1", reg_r_data_b, reg_r_valid_b);
        end
    endtask

    task automatic test_clear();
        do_write(5'd3, 16'h5555);
        clr_req    = 1'b1;
        reg_w_en   = 1'b1;
        reg_w_idx  = 5'd4;
        reg_w_data = 16'h7777;
        cycle();
        idle();
        for (int j = 1; j <= DEPTH; j++) begin
            reg_r_en_a  = 1'b1;
            reg_r_idx_a = ADDR_W'($urandom_range(0, DEPTH - 1));
            reg_r_en_b  = 1'b1;
            reg_r_idx_b = ADDR_W'($urandom_range(0, DEPTH - 1));
            cycle();
            n_cmp++;
            if (ready !== (j == DEPTH) || reg_r_valid_a !== 1'b0 || reg_r_valid_b !== 1'b0) begin
                n_err++;
                $display("FAIL clear_sweep cyc%0d: rdy=%b va=%b vb=%b expected %b 0 0",
                         j, ready, reg_r_valid_a, reg_r_valid_b, (j == DEPTH));
            end
        end
        reg_r_idx_a = 5'd3;
        reg_r_idx_b = 5'd4;
        cycle();
        idle();
        n_cmp++;
        if (reg_r_data_a !== 16'h0000 || reg_r_data_b !== 16'h0000 ||
            reg_r_valid_a !== 1'b1 || reg_r_valid_b !== 1'b1) begin
            n_err++;
            $display("FAIL post_clear: r3=%h r4=%h va=%b vb=%b expected 0000 0000 1 1",
                     reg_r_data_a, reg_r_data_b, reg_r_valid_a, reg_r_valid_b);
        end
    endtask

    task automatic test_async_reset();
        // Reset while READY with live read data
        do_write(5'd9, 16'hC3C3);
        reg_r_en_a  = 1'b1;
        reg_r_idx_a = 5'd9;
        reg_r_en_b  = 1'b1;
        reg_r_idx_b = 5'd9;
        cycle();
        idle();
        reset = 1'b0;
        #1;
        mdl_reset();
        n_cmp++;
        if (ready !== 1'b0 || reg_r_data_a !== '0 || reg_r_data_b !== '0 ||
            reg_r_valid_a !== 1'b0 || reg_r_valid_b !== 1'b0) begin
            n_err++;
            $display("FAIL async_rst_ready: rdy=%b da=%h db=%h va=%b vb=%b expected all 0",
                     ready, reg_r_data_a, reg_r_data_b, reg_r_valid_a, reg_r_valid_b);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (10) cycle();
        // Reset at INIT cycle 10, then a full sweep again
        reset = 1'b0;
        #1;
        mdl_reset();
        n_cmp++;
        if (ready !== 1'b0 || reg_r_valid_a !== 1'b0 || reg_r_data_a !== '0) begin
            n_err++;
            $display("FAIL async_rst_init: rdy=%b va=%b da=%h expected 0 0 0",
                     ready, reg_r_valid_a, reg_r_data_a);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle();
            n_cmp++;
            if (ready !== (i >= DEPTH)) begin
                n_err++;
                $display("FAIL reinit_ready cyc%0d: got %b expected %b", i, ready, (i >= DEPTH));
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 2500; n++) begin
            reg_r_en_a  = 1'($urandom_range(0, 1));
            reg_r_idx_a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                                      : ADDR_W'($urandom_range(0, 7));
            reg_r_en_b  = 1'($urandom_range(0, 1));
            reg_r_idx_b = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH - 1))
                                                      : ADDR_W'($urandom_range(0, 7));
            reg_w_en    = 1'($urandom_range(0, 1));
            reg_w_idx   = ADDR_W'($urandom_range(0, 7));
            reg_w_data  = DATA_W'($urandom);
            clr_req     = ($urandom_range(0, 199) == 0);
            cycle();
            n_cmp++;
            if (ready !== (mdl_init_left == 0) ||
                reg_r_valid_a !== mdl_valid_a || reg_r_data_a !== mdl_data_a ||
                reg_r_valid_b !== mdl_valid_b || reg_r_data_b !== mdl_data_b) begin
                n_err++;
                $display("FAIL random n%0d: rdy=%b va=%b da=%h vb=%b db=%h expected %b %b %h %b %h",
                         n, ready, reg_r_valid_a, reg_r_data_a, reg_r_valid_b, reg_r_data_b,
                         (mdl_init_left == 0), mdl_valid_a, mdl_data_a, mdl_valid_b, mdl_data_b);
            end
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_write_read();
        test_r0();
        test_collision();
        test_clear();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
